dds_lut_sequencer: RTL and testbench
====================================

// Module: dds_lut_sequencer
// PURPOSE
//  Playback/reprogram controller for the 16x6 reprogrammable waveform LUT in the DDS core.
//  Runs a phase accumulator that drives the LUT read port each cycle and emits one sample per cycle.
//  Schedules host LUT writes around playback reads: same-address collisions deferred, FTW changes
//  phase-continuous, stop request drains to a phase wrap (clean zero-phase stop).
// PARAMETERS
//  WW  6   LUT word width
//  AW  4   LUT address width (DEPTH = 2**AW)
//  PW  12  phase accumulator width (PW >= AW+2)
// PORTS
//  clk        in   1     clock; all state updates on rising edge
//  rst        in   1     synchronous reset, active-high
//  en         in   1     level: 1 = run playback, 0 = drain to wrap and stop
//  ftw        in   PW    frequency tuning word
//  ftw_ld     in   1     pulse: capture ftw
//  wr_req     in   1     host write request; wr_addr/wr_data held stable until wr_ack
//  wr_addr    in   AW    host write address
//  wr_data    in   WW    host write data
//  wr_ack     out  1     one-cycle pulse, coincident with lut_we
//  lut_we     out  1     LUT write enable
//  lut_wa     out  AW    LUT write address
//  lut_wd     out  WW    LUT write data
//  lut_re     out  1     LUT read enable
//  lut_ra     out  AW    LUT read address
//  lut_rd     in   WW    LUT read data, valid 1 cycle after lut_re
//  sample     out  WW+1  two's-complement output sample
//  sample_vld out  1     sample valid
//  busy       out  1     1 in RUN or DRAIN
// BEHAVIOUR
//  Reset: state=IDLE, phase=0, ftw_act=0, ftw_pend_v=0; all outputs 0.
//  FSM: IDLE -en-> RUN; RUN -!en-> DRAIN; DRAIN -en-> RUN (no stop);
//   DRAIN -wrap or ftw_act==0-> IDLE. wrap = carry out of phase+ftw_act.
//  RUN/DRAIN: phase <= phase+ftw_act (mod 2**PW) every cycle; lut_re=1; lut_ra from current phase.
//  IDLE: phase holds; lut_re=0.
//  ftw_ld in IDLE: ftw_act <= ftw next cycle. In RUN/DRAIN: ftw_pend <= ftw, ftw_pend_v=1;
//   moved to ftw_act on the cycle after the next wrap. Later ftw_ld before that wrap overwrites.
//  Pipeline: cycle t lut_re/lut_ra; t+1 lut_rd; t+2 sample/sample_vld registered. Latency 2.
//  sample_vld = lut_re delayed 2 cycles; sample holds last value when sample_vld=0.
//  Writes: wr_req seen at t -> lut_we/wr_ack at t+1 (lut_wa=wr_addr, lut_wd=wr_data).
//   In RUN/DRAIN, if wr_addr == lut_ra of that cycle, defer one cycle; after one deferral
//   issue unconditionally (that read returns old or new word; both legal).
//   wr_req ignored the cycle after wr_ack (no double write).
//  Simultaneous ftw_ld + wrap: old ftw_pend applied, new ftw becomes pending.
//  rst mid-operation: immediate return to reset state; in-flight write dropped, no wr_ack.
// CONFIGURATION
//  DDS_QUARTER_WAVE_EN defined: LUT holds quarter sine. q = phase[PW-1 -: 2],
//   idx = phase[PW-3 -: AW]; lut_ra = q[0] ? ~idx : idx; sample = q[1] ? -{0,rd} : {0,rd}
//   (q[1] pipelined 2 cycles with the read). Collision check uses mirrored lut_ra.
//  Not defined: lut_ra = phase[PW-1 -: AW]; sample = {1'b0, lut_rd}.
// TESTING (PW=12, AW=4, WW=6)
//  IDLE, wr_req addr=3 data=0x2A -> next cycle lut_we=1, lut_wa=3, lut_wd=0x2A, wr_ack=1 for 1 cycle.
//  ftw_ld 0x100, en=1 -> lut_ra 0,1,..,15,0 one/cycle; first sample_vld 2 cycles after first lut_re.
//  RUN ftw 0x100, ftw_ld 0x200 at phase 0x500 -> step 0x100 until wrap, then lut_ra 0,2,4,...
//  en=0 at phase 0x300 -> DRAIN until wrap; then IDLE, phase=0, lut_re=0, busy=0; ftw_act=0 -> IDLE next cycle.
//  RUN, wr_addr equal to current lut_ra -> lut_we delayed 1 cycle; wr_ack on issue cycle only.
//  QUARTER_WAVE_EN, ftw 0x040 -> lut_ra 0..15,15..0,0..15,15..0; 2nd half samples negated; rst mid-run -> all 0.

Source files
------------

// File: rtl/dds_lut_sequencer.sv
// Playback/reprogram sequencer for the DDS waveform LUT: phase accumulator read stream,
// collision-aware host writes, phase-continuous FTW updates, drain-to-wrap stop.
// Optional feature macro: DDS_QUARTER_WAVE_EN (quarter-sine LUT with mirrored address / sign).
module dds_lut_sequencer #(
  parameter int unsigned WW = 6,
  parameter int unsigned AW = 4,
  parameter int unsigned PW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [PW-1:0] ftw,
  input  logic          ftw_ld,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [WW-1:0] wr_data,
  output logic          wr_ack,
  output logic          lut_we,
  output logic [AW-1:0] lut_wa,
  output logic [WW-1:0] lut_wd,
  output logic          lut_re,
  output logic [AW-1:0] lut_ra,
  input  logic [WW-1:0] lut_rd,
  output logic [WW:0]   sample,
  output logic          sample_vld,
  output logic          busy
);

  localparam int unsigned SW = WW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_stop;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] r_ftw_act;
  logic [PW-1:0] r_ftw_pend;
  logic          r_ftw_pend_v;
  logic [PW:0]   w_sum;
  logic          w_wrap;
  logic          w_active;
  logic [AW-1:0] w_ra;

  logic          r_lut_we;
  logic          r_wr_ack;
  logic          r_wr_defer;
  logic [AW-1:0] r_lut_wa;
  logic [WW-1:0] r_lut_wd;
  logic          w_wr_accept;
  logic          w_collide;

  logic          r_re_d1;
  logic          r_vld;
  logic [SW-1:0] r_sample;
  logic [SW-1:0] w_mag;

  assign w_sum    = {1'b0, r_phase} + {1'b0, r_ftw_act};
  assign w_wrap   = w_sum[PW];
  assign w_active = (r_state != S_IDLE);
  assign w_mag    = {1'b0, lut_rd};

`ifdef DDS_QUARTER_WAVE_EN
  logic [1:0]    w_q;
  logic [AW-1:0] w_idx;
  logic          r_neg_d1;
  assign w_q   = r_phase[PW-1 -: 2];
  assign w_idx = r_phase[PW-3 -: AW];
  // Odd quadrants walk the quarter table backwards.
  assign w_ra  = w_q[0] ? ~w_idx : w_idx;
`else
  assign w_ra  = r_phase[PW-1 -: AW];
`endif

  // Next-state logic; w_stop marks the DRAIN -> IDLE hand-off.
  always_comb begin
    w_state_nxt = r_state;
    w_stop      = 1'b0;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN:   if (!en) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (en) begin
          w_state_nxt = S_RUN;
        end else if (w_wrap || (r_ftw_act == '0)) begin
          w_state_nxt = S_IDLE;
          w_stop      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, phase accumulator and tuning-word bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_ftw_act    <= '0;
      r_ftw_pend   <= '0;
      r_ftw_pend_v <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_active) begin
        r_phase <= w_stop ? '0 : w_sum[PW-1:0];
        if (w_wrap && r_ftw_pend_v) begin
          r_ftw_act    <= r_ftw_pend;
          r_ftw_pend_v <= 1'b0;
        end
        if (ftw_ld) begin
          r_ftw_pend   <= ftw;
          r_ftw_pend_v <= 1'b1;
        end
      end else if (ftw_ld) begin
        // Stopped: a fresh word takes effect at once and supersedes anything pending.
        r_ftw_act    <= ftw;
        r_ftw_pend_v <= 1'b0;
      end
    end
  end

  // Host write scheduling: one deferral on a same-address read, never twice in a row.
  assign w_wr_accept = wr_req && !r_wr_ack;
  assign w_collide   = w_active && (wr_addr == w_ra) && !r_wr_defer;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lut_we   <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_wr_defer <= 1'b0;
      r_lut_wa   <= '0;
      r_lut_wd   <= '0;
    end else begin
      r_lut_we <= 1'b0;
      r_wr_ack <= 1'b0;
      if (w_wr_accept) begin
        if (w_collide) begin
          r_wr_defer <= 1'b1;
        end else begin
          r_lut_we   <= 1'b1;
          r_wr_ack   <= 1'b1;
          r_lut_wa   <= wr_addr;
          r_lut_wd   <= wr_data;
          r_wr_defer <= 1'b0;
        end
      end
    end
  end

  // Two-stage sample pipeline aligned with the synchronous LUT read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_re_d1  <= 1'b0;
      r_vld    <= 1'b0;
      r_sample <= '0;
`ifdef DDS_QUARTER_WAVE_EN
      r_neg_d1 <= 1'b0;
`endif
    end else begin
      r_re_d1 <= w_active;
      r_vld   <= r_re_d1;
`ifdef DDS_QUARTER_WAVE_EN
      r_neg_d1 <= w_q[1];
      if (r_re_d1) r_sample <= r_neg_d1 ? SW'(-w_mag) : w_mag;
`else
      if (r_re_d1) r_sample <= w_mag;
`endif
    end
  end

  assign lut_re     = w_active;
  assign lut_ra     = w_ra;
  assign busy       = w_active;
  assign lut_we     = r_lut_we;
  assign wr_ack     = r_wr_ack;
  assign lut_wa     = r_lut_wa;
  assign lut_wd     = r_lut_wd;
  assign sample     = r_sample;
  assign sample_vld = r_vld;

endmodule

// File: tb/tb_dds_lut_sequencer.sv
// Self-checking bench for dds_lut_sequencer: directed scenarios plus randomized traffic
// compared against a behavioural model of the sequencer and a simple LUT memory.
module tb_dds_lut_sequencer;

  localparam int WW    = 6;
  localparam int AW    = 4;
  localparam int PW    = 12;
  localparam int DEPTH = 1 << AW;
  localparam int PSPAN = 1 << PW;
  localparam int SMOD  = 1 << (WW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [PW-1:0] ftw = '0;
  logic          ftw_ld = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [WW-1:0] wr_data = '0;
  logic          wr_ack, lut_we, lut_re, sample_vld, busy;
  logic [AW-1:0] lut_wa, lut_ra;
  logic [WW-1:0] lut_wd;
  logic [WW-1:0] lut_rd = '0;
  logic [WW:0]   sample;

  int checks = 0;
  int failures = 0;

  dds_lut_sequencer #(.WW(WW), .AW(AW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .ftw(ftw), .ftw_ld(ftw_ld),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .lut_we(lut_we), .lut_wa(lut_wa), .lut_wd(lut_wd),
    .lut_re(lut_re), .lut_ra(lut_ra), .lut_rd(lut_rd),
    .sample(sample), .sample_vld(sample_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  // LUT memory: synchronous read, data one cycle after lut_re.
  logic [WW-1:0] mem [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (lut_we) mem[lut_wa] <= lut_wd;
    if (lut_re) lut_rd <= mem[lut_ra];
  end

  function automatic int ra_of(int p);
    int q, idx;
`ifdef DDS_QUARTER_WAVE_EN
    q   = p / (PSPAN / 4);
    idx = (p / (PSPAN / 4 / DEPTH)) % DEPTH;
    return (q % 2 == 1) ? (DEPTH - 1 - idx) : idx;
`else
    q   = 0;
    idx = p / (PSPAN / DEPTH);
    return idx + q;
`endif
  endfunction

  function automatic bit neg_of(int p);
`ifdef DDS_QUARTER_WAVE_EN
    return p >= PSPAN / 2;
`else
    return (p < 0);
`endif
  endfunction

  // Directed-test record of LUT contents.
  int lutv [DEPTH] = '{default: 0};

  function automatic int smp_of(int p);
    int v;
    v = lutv[ra_of(p)];
    return neg_of(p) ? (SMOD - v) % SMOD : v;
  endfunction

  // Behavioural reference model, one step per rising edge.
  bit m_busy, m_drn, m_pend_v, m_we, m_def, m_r1v, m_r1neg, m_vld;
  int m_phase, m_ftw, m_pend, m_wa, m_wd, m_r1val, m_smp;
  int mmem [DEPTH] = '{default: 0};

  always @(posedge clk) begin : model
    int ra, rdv, sum, old_ftw;
    bit wrap, rneg;
    ra   = ra_of(m_phase);
    rdv  = mmem[ra];
    rneg = neg_of(m_phase);
    if (m_we) mmem[m_wa] = m_wd;
    if (rst) begin
      m_busy = 0; m_drn = 0; m_pend_v = 0; m_we = 0; m_def = 0;
      m_r1v = 0; m_r1neg = 0; m_vld = 0;
      m_phase = 0; m_ftw = 0; m_pend = 0; m_wa = 0; m_wd = 0; m_r1val = 0; m_smp = 0;
    end else begin
      if (m_r1v) m_smp = m_r1neg ? (SMOD - m_r1val) % SMOD : m_r1val;
      m_vld   = m_r1v;
      m_r1v   = m_busy;
      m_r1val = rdv;
      m_r1neg = rneg;
      if (wr_req && !m_we) begin
        if (m_busy && int'(wr_addr) == ra && !m_def) begin
          m_def = 1; m_we = 0;
        end else begin
          m_we = 1; m_wa = int'(wr_addr); m_wd = int'(wr_data); m_def = 0;
        end
      end else begin
        m_we = 0;
      end
      if (!m_busy) begin
        if (ftw_ld) begin m_ftw = int'(ftw); m_pend_v = 0; end
        if (en) begin m_busy = 1; m_drn = 0; end
      end else begin
        old_ftw = m_ftw;
        sum     = m_phase + m_ftw;
        wrap    = sum >= PSPAN;
        m_phase = sum % PSPAN;
        if (wrap && m_pend_v) begin m_ftw = m_pend; m_pend_v = 0; end
        if (ftw_ld) begin m_pend = int'(ftw); m_pend_v = 1; end
        if (!m_drn) begin
          if (!en) m_drn = 1;
        end else if (en) begin
          m_drn = 0;
        end else if (wrap || old_ftw == 0) begin
          m_busy = 0; m_drn = 0; m_phase = 0;
        end
      end
    end
  end

  task automatic stop_and_wait(output bit stopped);
    en = 1'b0;
    stopped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin stopped = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, lut_re, lut_we, wr_ack, sample_vld} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {busy, lut_re, lut_we, wr_ack, sample_vld});
    end
    checks++;
    if (sample !== '0 || lut_ra !== '0) begin
      failures++; $display("FAIL reset_data sample=%0h ra=%0h exp=0", sample, lut_ra);
    end
    checks++;
    if (lut_wa !== '0 || lut_wd !== '0) begin
      failures++; $display("FAIL reset_wr wa=%0h wd=%0h exp=0", lut_wa, lut_wd);
    end
  endtask

  task automatic test_write_idle;
    logic [WW-1:0] d;
    wr_req = 1'b1; wr_addr = 4'd3; wr_data = 6'h2A;
    @(negedge clk);
    checks++;
    if (lut_we !== 1'b1 || wr_ack !== 1'b1 || lut_wa !== 4'd3 || lut_wd !== 6'h2A) begin
      failures++; $display("FAIL idle_write we=%b ack=%b wa=%0h wd=%0h exp 1 1 3 2a", lut_we, wr_ack, lut_wa, lut_wd);
    end
    @(negedge clk);
    checks++;
    if (lut_we !== 1'b0 || wr_ack !== 1'b0) begin
      failures++; $display("FAIL no_double_write we=%b ack=%b exp 0 0", lut_we, wr_ack);
    end
    wr_req = 1'b0;
    lutv[3] = 'h2A;
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) begin
      d = WW'($urandom);
      wr_req = 1'b1; wr_addr = AW'(a); wr_data = d;
      @(negedge clk);
      checks++;
      if (lut_we !== 1'b1 || lut_wa !== AW'(a) || lut_wd !== d) begin
        failures++; $display("FAIL preload we=%b wa=%0h wd=%0h exp 1 %0h %0h", lut_we, lut_wa, lut_wd, a, d);
      end
      wr_req = 1'b0;
      lutv[a] = int'(d);
      @(negedge clk);
    end
  endtask

  task automatic test_sweep;
    ftw = 12'h100; ftw_ld = 1'b1; en = 1'b1;
    @(negedge clk);
    ftw_ld = 1'b0;
    for (int k = 0; k < 19; k++) begin
      checks++;
      if (lut_re !== 1'b1 || int'(lut_ra) != ra_of((k * 256) % PSPAN)) begin
        failures++; $display("FAIL sweep_ra k=%0d re=%b ra=%0d exp=%0d", k, lut_re, lut_ra, ra_of((k * 256) % PSPAN));
      end
      checks++;
      if (sample_vld !== (k >= 2)) begin
        failures++; $display("FAIL sweep_vld k=%0d got=%b exp=%b", k, sample_vld, k >= 2);
      end
      if (k >= 2) begin
        checks++;
        if (int'(sample) != smp_of(((k - 2) * 256) % PSPAN)) begin
          failures++; $display("FAIL sweep_sample k=%0d got=%0h exp=%0h", k, sample, smp_of(((k - 2) * 256) % PSPAN));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_drain;
    int n;
    n = 0;
    checks++;
    if (busy !== 1'b1 || int'(lut_ra) != ra_of(12'h300)) begin
      failures++; $display("FAIL drain_start busy=%b ra=%0d exp 1 %0d", busy, lut_ra, ra_of(12'h300));
    end
    en = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      checks++;
      if (int'(lut_ra) != ra_of(12'h300 + i * 256)) begin
        failures++; $display("FAIL drain_ra i=%0d got=%0d exp=%0d", i, lut_ra, ra_of(12'h300 + i * 256));
      end
    end
    checks++;
    if (n != 12) begin
      failures++; $display("FAIL drain_len got=%0d exp=12", n);
    end
    checks++;
    if (lut_re !== 1'b0 || lut_ra !== '0) begin
      failures++; $display("FAIL drain_stop re=%b ra=%0h exp 0 0", lut_re, lut_ra);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sample_vld !== 1'b0 || int'(sample) != smp_of(12'hF00)) begin
      failures++; $display("FAIL drain_hold vld=%b sample=%0h exp 0 %0h", sample_vld, sample, smp_of(12'hF00));
    end
    ftw = '0; ftw_ld = 1'b1; en = 1'b1;
    @(negedge clk);
    ftw_ld = 1'b0; en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL zero_ftw_run got=%b exp=1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL zero_ftw_drain got=%b exp=1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL zero_ftw_stop got=%b exp=0", busy); end
  endtask

  task automatic test_ftw_change;
    int p, step;
    bit stopped;
    ftw = 12'h100; ftw_ld = 1'b1; en = 1'b1;
    @(negedge clk);
    ftw_ld = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (int'(lut_ra) != ra_of(12'h500)) begin
      failures++; $display("FAIL ftw_pre got=%0d exp=%0d", lut_ra, ra_of(12'h500));
    end
    ftw = 12'h200; ftw_ld = 1'b1;
    @(negedge clk);
    ftw_ld = 1'b0;
    p = 12'h500; step = 12'h100;
    for (int j = 0; j < 20; j++) begin
      p += step;
      if (p >= PSPAN) begin p -= PSPAN; step = 12'h200; end
      checks++;
      if (int'(lut_ra) != ra_of(p)) begin
        failures++; $display("FAIL ftw_change j=%0d got=%0d exp=%0d", j, lut_ra, ra_of(p));
      end
      @(negedge clk);
    end
    stop_and_wait(stopped);
    checks++;
    if (!stopped) begin failures++; $display("FAIL ftw_stop busy=%b exp=0", busy); end
  endtask

  task automatic test_collision;
    logic [AW-1:0] a;
    logic [WW-1:0] d;
    bit stopped;
    ftw = 12'h100; ftw_ld = 1'b1; en = 1'b1;
    @(negedge clk);
    ftw_ld = 1'b0;
    repeat (2) @(negedge clk);
    a = AW'(ra_of(12'h200)); d = WW'($urandom);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    checks++;
    if (lut_we !== 1'b0 || wr_ack !== 1'b0) begin
      failures++; $display("FAIL collide_defer we=%b ack=%b exp 0 0", lut_we, wr_ack);
    end
    @(negedge clk);
    checks++;
    if (lut_we !== 1'b1 || wr_ack !== 1'b1 || lut_wa !== a || lut_wd !== d) begin
      failures++; $display("FAIL collide_issue we=%b ack=%b wa=%0h wd=%0h exp 1 1 %0h %0h", lut_we, wr_ack, lut_wa, lut_wd, a, d);
    end
    wr_req = 1'b0;
    lutv[a] = int'(d);
    @(negedge clk);
    checks++;
    if (lut_we !== 1'b0 || wr_ack !== 1'b0) begin
      failures++; $display("FAIL collide_single we=%b ack=%b exp 0 0", lut_we, wr_ack);
    end
    a = AW'((ra_of(12'h500) + 7) % DEPTH); d = WW'($urandom);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    checks++;
    if (lut_we !== 1'b1 || wr_ack !== 1'b1 || lut_wa !== a) begin
      failures++; $display("FAIL run_write we=%b ack=%b wa=%0h exp 1 1 %0h", lut_we, wr_ack, lut_wa, a);
    end
    wr_req = 1'b0;
    lutv[a] = int'(d);
    stop_and_wait(stopped);
    checks++;
    if (!stopped) begin failures++; $display("FAIL collide_stop busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    ftw = 12'h100; ftw_ld = 1'b1; en = 1'b1;
    @(negedge clk);
    ftw_ld = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1; wr_req = 1'b1; wr_addr = 4'd5; wr_data = WW'($urandom);
    @(negedge clk);
    checks++;
    if ({busy, lut_re, lut_we, wr_ack} !== 4'b0 || lut_ra !== '0) begin
      failures++; $display("FAIL midrst_ctl flags=%b ra=%0h exp 0", {busy, lut_re, lut_we, wr_ack}, lut_ra);
    end
    @(negedge clk);
    checks++;
    if (sample_vld !== 1'b0 || sample !== '0) begin
      failures++; $display("FAIL midrst_sample vld=%b sample=%0h exp 0 0", sample_vld, sample);
    end
    rst = 1'b0; wr_req = 1'b0; en = 1'b1;
    @(negedge clk);
    checks++;
    if (lut_we !== 1'b0 || wr_ack !== 1'b0) begin
      failures++; $display("FAIL midrst_dropped we=%b ack=%b exp 0 0", lut_we, wr_ack);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || lut_ra !== '0) begin
      failures++; $display("FAIL midrst_ftw0 busy=%b ra=%0h exp 1 0", busy, lut_ra);
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random;
    int r;
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (lut_re !== m_busy || busy !== m_busy || int'(lut_ra) != ra_of(m_phase)) begin
        failures++; $display("FAIL rnd_read c=%0d re=%b busy=%b ra=%0d exp %b %0d", c, lut_re, busy, lut_ra, m_busy, ra_of(m_phase));
      end
      checks++;
      if (lut_we !== m_we || wr_ack !== m_we || (m_we && (int'(lut_wa) != m_wa || int'(lut_wd) != m_wd))) begin
        failures++; $display("FAIL rnd_write c=%0d we=%b ack=%b wa=%0h wd=%0h exp %b %0h %0h", c, lut_we, wr_ack, lut_wa, lut_wd, m_we, m_wa, m_wd);
      end
      checks++;
      if (sample_vld !== m_vld || int'(sample) != m_smp) begin
        failures++; $display("FAIL rnd_sample c=%0d vld=%b sample=%0h exp %b %0h", c, sample_vld, sample, m_vld, m_smp);
      end
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      ftw_ld = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 3);
      case (r)
        0: ftw = 12'h040;
        1: ftw = 12'h100;
        2: ftw = PW'($urandom_range(1, PSPAN - 1));
        default: ftw = PW'($urandom_range(0, 255));
      endcase
      if (wr_req && wr_ack) begin
        wr_req = 1'b0;
      end else if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req = 1'b1; wr_addr = AW'($urandom); wr_data = WW'($urandom);
      end
      @(negedge clk);
    end
    rst = 1'b0; en = 1'b0; ftw_ld = 1'b0; wr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_idle();
    test_sweep();
    test_drain();
    test_ftw_change();
    test_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
